// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   OP_J / OP_JAL : opcodes [31:27] recognised by the optional jump predecoder
//   NOP_WORD      : instruction presented when the queue is empty
//   fetch_entry_t : one queue entry, {pc, inst}
//   is_jump()     : true for an unconditional j / jal word
package imem_fetch_pkg;

    localparam logic [4:0]  OP_J     = 5'd1;
    localparam logic [4:0]  OP_JAL   = 5'd3;
    localparam logic [31:0] NOP_WORD = 32'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic is_jump(input logic [31:0] word);
        return (word[31:27] == OP_J) || (word[31:27] == OP_JAL);
    endfunction

endpackage

// File: rtl/imem_prefetch_queue_fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetch_entry_t.
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   flush_i      synchronous flush; empties the buffer, wins over push/pop
//   push_i       write push_data_i at the tail
//   push_data_i  entry to enqueue
//   pop_i        drop the head entry (ignored when empty)
//   head_o       entry at the head (undefined content when count_o == 0)
//   count_o      number of entries held, 0..DEPTH
module fetch_fifo
    import imem_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push_ok;
    logic           pop_ok;

    assign push_ok = push_i && (count_q != CW'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count_q gates visibility of every slot.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/imem_prefetch_queue.sv
// imem_prefetch_queue: sequential instruction prefetcher between a 1-cycle
// synchronous imem and the fetch/decode latch.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-low reset
//   redirect, redirect_pc   flush and restart fetch at redirect_pc
//   imem_addr, imem_req     read request to imem (combinational)
//   imem_q                  read data, valid the cycle after imem_req
//   inst, inst_pc           head entry (zero when inst_valid = 0)
//   inst_valid, inst_ready  delivery handshake to the pipeline
//   occupancy               entries held in the queue
// Optional feature: define PREDECODE_JUMP_EN to follow j/jal targets at
// enqueue time instead of waiting for the pipeline to redirect.
module imem_prefetch_queue
    import imem_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [31:0]              imem_addr,
    output logic                     imem_req,
    input  logic [31:0]              imem_q,
    output logic [31:0]              inst,
    output logic [31:0]              inst_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]    fpc_q, fpc_d;
    logic           inflight_q, inflight_d;
    logic [31:0]    inflight_pc_q, inflight_pc_d;
    logic           kill_q, kill_d;

    logic [CW-1:0]  count;
    logic [CW-1:0]  credit_used;
    fetch_entry_t   head;
    fetch_entry_t   ret_entry;
    logic           push;
    logic           pop;
    logic           jump_hit;

    // One credit per held entry plus one for the outstanding read, so a
    // return always has a free slot.
    assign credit_used = count + CW'(inflight_q);
    assign imem_req    = reset & (redirect | (credit_used < CW'(DEPTH)));
    assign imem_addr   = redirect ? redirect_pc : fpc_q;

    assign ret_entry = '{pc: inflight_pc_q, inst: imem_q};
    assign push      = inflight_q & ~kill_q & ~redirect;
    assign pop       = inst_valid & inst_ready & ~redirect;

`ifdef PREDECODE_JUMP_EN
    assign jump_hit = push & is_jump(imem_q);
`else
    assign jump_hit = 1'b0;
`endif

    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = imem_req;
        inflight_pc_d = inflight_pc_q;
        kill_d        = 1'b0;
        if (imem_req) begin
            fpc_d         = imem_addr + 32'd1;
            inflight_pc_d = imem_addr;
        end
        // push already excludes redirect, so an external redirect wins here.
        if (jump_hit) begin
            fpc_d  = {5'b0, imem_q[26:0]};
            kill_d = imem_req;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fpc_q         <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_ni      (reset),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (ret_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? head.inst : NOP_WORD;
    assign inst_pc    = inst_valid ? head.pc : 32'd0;
    assign occupancy  = count;

endmodule

// File: tb/tb_imem_prefetch_queue.sv
module tb_imem_prefetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_q = 32'd0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;
    bit jmode  = 1'b0;

    imem_prefetch_queue #(.DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_q      (imem_q),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .occupancy   (occupancy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit jm);
        if (jm && a == 32'd5) return 32'h0800_0100;
        return a ^ 32'hA5A5_0000;
    endfunction

    // 1-cycle synchronous imem model
    always @(posedge clock) begin
        if (imem_req) imem_q <= mem_word(imem_addr, jmode);
    end

    task automatic step(input logic rst, input logic rd, input logic [31:0] rpc, input logic rdy);
        @(negedge clock);
        reset       = rst;
        redirect    = rd;
        redirect_pc = rpc;
        inst_ready  = rdy;
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b1, 32'h55, 1'b1);
        step(1'b0, 1'b1, 32'h55, 1'b1);
        checks++;
        if ({imem_req, inst_valid, inst, inst_pc, occupancy} !== 68'd0) begin
            errors++;
            $display("FAIL reset_state: req=%0b valid=%0b inst=%h pc=%h occ=%0d, required all zero",
                     imem_req, inst_valid, inst, inst_pc, occupancy);
        end
        step(1'b1, 1'b0, 32'd0, 1'b1);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL first_issue: req=%0b addr=%h, required req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream;
        step(1'b1, 1'b0, 32'd0, 1'b1);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_latency: valid=%0b one cycle after release, required 0", inst_valid);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            checks++;
            if ({inst_valid, inst_pc, inst, occupancy} !== {1'b1, 32'(k), 32'(k) ^ 32'hA5A5_0000, 3'd1}) begin
                errors++;
                $display("FAIL stream_%0d: valid=%0b pc=%h inst=%h occ=%0d, required valid=1 pc=%h inst=%h occ=1",
                         k, inst_valid, inst_pc, inst, occupancy, k, 32'(k) ^ 32'hA5A5_0000);
            end
        end
    endtask

    task automatic test_stall;
        logic [2:0] occ_e;
        logic       req_e;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0);
            occ_e = (i < 3) ? 3'(i + 1) : 3'd4;
            req_e = (i < 2);
            checks++;
            if ({inst_valid, inst_pc, occupancy, imem_req} !== {1'b1, 32'd8, occ_e, req_e}) begin
                errors++;
                $display("FAIL stall_%0d: valid=%0b pc=%h occ=%0d req=%0b, required valid=1 pc=8 occ=%0d req=%0b",
                         i, inst_valid, inst_pc, occupancy, imem_req, occ_e, req_e);
            end
        end
        for (int k = 8; k < 16; k++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            checks++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, 32'(k), 32'(k) ^ 32'hA5A5_0000}) begin
                errors++;
                $display("FAIL release_%0d: valid=%0b pc=%h inst=%h, required pc=%h", k, inst_valid, inst_pc, inst, k);
            end
        end
    endtask

    task automatic test_redirect;
        step(1'b1, 1'b1, 32'd7, 1'b0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd7}) begin
            errors++;
            $display("FAIL redir_issue: req=%0b addr=%h, required req=1 addr=7", imem_req, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0);
            checks++;
            if (occupancy !== 3'(i)) begin
                errors++;
                $display("FAIL fill_%0d: occ=%0d, required %0d", i, occupancy, i);
            end
        end
        // queue holds 7,8,9 with pc 10 in flight; redirect and ready together
        step(1'b1, 1'b1, 32'h40, 1'b1);
        checks++;
        if ({inst_valid, inst_pc, imem_req, imem_addr, occupancy} !== {1'b1, 32'd7, 1'b1, 32'h40, 3'd3}) begin
            errors++;
            $display("FAIL redir_cycle: valid=%0b pc=%h req=%0b addr=%h occ=%0d, required 1 7 1 40 3",
                     inst_valid, inst_pc, imem_req, imem_addr, occupancy);
        end
        step(1'b1, 1'b0, 32'd0, 1'b1);
        checks++;
        if ({inst_valid, occupancy, inst, inst_pc} !== 68'd0) begin
            errors++;
            $display("FAIL redir_flush: valid=%0b occ=%0d inst=%h pc=%h, required all zero",
                     inst_valid, occupancy, inst, inst_pc);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            checks++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h40 + 32'(k), (32'h40 + 32'(k)) ^ 32'hA5A5_0000}) begin
                errors++;
                $display("FAIL redir_seq_%0d: valid=%0b pc=%h inst=%h, required pc=%h",
                         k, inst_valid, inst_pc, inst, 32'h40 + 32'(k));
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'hFFFF_FFFE;
        exp_pc[1] = 32'hFFFF_FFFF;
        exp_pc[2] = 32'h0000_0000;
        exp_pc[3] = 32'h0000_0001;
        step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            checks++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, exp_pc[k], exp_pc[k] ^ 32'hA5A5_0000}) begin
                errors++;
                $display("FAIL wrap_%0d: valid=%0b pc=%h inst=%h, required pc=%h", k, inst_valid, inst_pc, inst, exp_pc[k]);
            end
        end
    endtask

    task automatic test_jump;
        logic [32:0] exp_tail [3];
        logic [31:0] exp_addr;
`ifdef PREDECODE_JUMP_EN
        exp_tail[0] = {1'b0, 32'd0};
        exp_tail[1] = {1'b1, 32'h100};
        exp_tail[2] = {1'b1, 32'h101};
        exp_addr    = 32'h100;
`else
        exp_tail[0] = {1'b1, 32'd6};
        exp_tail[1] = {1'b1, 32'd7};
        exp_tail[2] = {1'b1, 32'd8};
        exp_addr    = 32'd7;
`endif
        jmode = 1'b1;
        step(1'b1, 1'b1, 32'd3, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        checks++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'd3}) begin
            errors++;
            $display("FAIL jump_pc3: valid=%0b pc=%h, required pc=3", inst_valid, inst_pc);
        end
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        checks++;
        if ({inst_valid, inst_pc, inst, imem_req, imem_addr} !== {1'b1, 32'd5, 32'h0800_0100, 1'b1, exp_addr}) begin
            errors++;
            $display("FAIL jump_word: valid=%0b pc=%h inst=%h req=%0b addr=%h, required pc=5 inst=08000100 req=1 addr=%h",
                     inst_valid, inst_pc, inst, imem_req, imem_addr, exp_addr);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            checks++;
            if ({inst_valid, inst_pc} !== exp_tail[k]) begin
                errors++;
                $display("FAIL jump_tail_%0d: valid=%0b pc=%h, required valid=%0b pc=%h",
                         k, inst_valid, inst_pc, exp_tail[k][32], exp_tail[k][31:0]);
            end
        end
        jmode = 1'b0;
    endtask

    task automatic test_mid_reset;
        step(1'b0, 1'b1, 32'h77, 1'b1);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL midreset_req: req=%0b with reset low and redirect high, required 0", imem_req);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        checks++;
        if ({inst_valid, inst, inst_pc, occupancy, imem_req} !== 68'd0) begin
            errors++;
            $display("FAIL midreset_state: valid=%0b inst=%h pc=%h occ=%0d req=%0b, required all zero",
                     inst_valid, inst, inst_pc, occupancy, imem_req);
        end
        step(1'b1, 1'b0, 32'd0, 1'b1);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL midreset_issue: req=%0b addr=%h, required req=1 addr=0", imem_req, imem_addr);
        end
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        checks++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'd0, 32'hA5A5_0000}) begin
            errors++;
            $display("FAIL midreset_first: valid=%0b pc=%h inst=%h, required pc=0 inst=a5a50000",
                     inst_valid, inst_pc, inst);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_jump();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_prefetch_queue.md
# imem_prefetch_queue

Instruction prefetch queue between the instruction memory and the processor's fetch stage. Issues sequential word-addressed reads to imem (PC+1 stepping), buffers returned words with their PCs in a small FIFO, and delivers them to the FD latch through a valid/ready handshake. A redirect from the pipeline (branch, jr, bex) flushes the queue and restarts fetch at the new PC.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; state clears on a rising edge with reset=0
- redirect  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address (word address)
- imem_addr  out  32  read address to imem; combinational
- imem_req  out  1  read issued this cycle
- imem_q  in  32  read data; valid in the cycle after the request (1-cycle synchronous imem)
- inst  out  32  head instruction; 32'b0 (nop) when inst_valid=0
- inst_pc  out  32  PC of head instruction; 0 when inst_valid=0
- inst_valid  out  1  head entry present
- inst_ready  in  1  processor consumes head this cycle (low while pipeline stalls)
- occupancy  out  $clog2(DEPTH)+1  entries held

## Operation
- State: fetch pointer fpc, FIFO of {pc, inst}, in-flight flag inflight with tag inflight_pc, kill flag.
- Issue: imem_req = reset & (redirect | (count + inflight < DEPTH)). imem_addr = redirect ? redirect_pc : fpc. On issue, fpc ← imem_addr + 1 (mod 2^32), inflight ← 1, inflight_pc ← imem_addr.
- Return: in the cycle after an issue, if the kill flag is clear, {inflight_pc, imem_q} is enqueued at the edge. A killed return is discarded.
- Pop: inst_valid & inst_ready & ~redirect dequeues the head.
- Redirect: the queue empties at the edge, the current return is killed, and the redirect_pc request is issued in the same cycle. A pop in the redirect cycle is ignored.
- Full: no issue while count + inflight = DEPTH. Enqueue never overflows because of the credit rule.
- Empty: inst_valid=0, inst=0, inst_pc=0. Data is never bypassed from imem_q to inst.
- Simultaneous enqueue and pop: occupancy unchanged, FIFO order preserved.

## Timing
- Reset values: inst_valid=0, inst=0, inst_pc=0, occupancy=0, imem_req=0, fpc=0, inflight=0, kill=0.
- First cycle with reset=1: imem_req=1, imem_addr=0.
- Redirect in cycle t: request at redirect_pc in t, data in t+1, inst_valid=1 with inst_pc=redirect_pc in t+2.
- Throughput is one instruction per cycle in steady state with inst_ready held high.
- reset=0 mid-operation overrides redirect and all other events. Everything returns to reset values at that edge, and any in-flight return is discarded.

## Configuration
- PREDECODE_JUMP_EN defined:
  - An enqueued word with opcode [31:27] = 5'd1 (j) or 5'd3 (jal) sets fpc ← {5'b0, word[26:0]} at the enqueue edge.
  - The sequential request issued in that same cycle is killed.
  - The jump word itself is still delivered with its own pc.
  - An external redirect in the same cycle takes priority.
- Undefined: fetch is purely sequential. The processor resolves j/jal itself and must redirect.

## Structure
- Shared package imem_fetch_pkg:
  - OP_J = 5'd1, OP_JAL = 5'd3
  - NOP_WORD = 32'b0
  - typedef fetch_entry_t {pc[31:0], inst[31:0]}
- One sub-module, fetch_fifo: DEPTH-entry storage of fetch_entry_t with wrap-around read/write pointers, count, sync flush, push/pop.
- Issue, credit, kill and redirect logic stay in imem_prefetch_queue.

## Test plan
- Reset release, imem model returns q = addr ^ 32'hA5A50000, inst_ready=1 → inst_pc 0,1,2,3… on consecutive cycles, first valid 2 cycles after release, inst matches the model.
- inst_ready=0 for 10 cycles → occupancy saturates at 4, imem_req=0 while full. On release, pcs continue in order with no gaps and no duplicates.
- Queue holding pcs 7..9 plus one in flight, redirect with redirect_pc=0x40 → two cycles later inst_pc=0x40. Pcs 7..10 never appear.
- redirect and inst_ready=1 with inst_valid=1 in the same cycle → pop ignored, occupancy=0 next cycle, no stale entry delivered.
- redirect_pc=32'hFFFFFFFE → delivered pcs FFFFFFFE, FFFFFFFF, 0, 1.
- With PREDECODE_JUMP_EN, word 32'h08000100 (j 0x100) at pc 5 → delivered pcs 5, 0x100, 0x101. pc 6 never delivered. Without the macro → pcs 5, 6, 7.
